// File: rtl/hwpe_ctrl_uloop_sched.sv
// Turns uloop offset sets into per-lane address commands held in a small ordered buffer.
// Latency: a pushed command reaches cmd_valid_o one cycle later (registered buffer, no bypass).
// Backpressure: cmd_ready_i low fills the buffer; uloop_enable_o throttles the uloop, and overflow is sticky.
module hwpe_ctrl_uloop_sched #(
    parameter int NB_REG     = 4,
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic                                 start_i,
    input  logic [NB_REG-1:0][ADDR_WIDTH-1:0]    base_addr_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 overflow_o,
    output logic                                 uloop_clear_o,
    output logic                                 uloop_enable_o,
    input  logic                                 uloop_valid_i,
    input  logic                                 uloop_done_i,
    input  logic [NB_REG-1:0][REG_WIDTH-1:0]     uloop_offs_i,
    output logic                                 cmd_valid_o,
    input  logic                                 cmd_ready_i,
    output logic [NB_REG-1:0][ADDR_WIDTH-1:0]    cmd_addr_o,
    output logic                                 cmd_last_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

    state_t                              state, state_nxt;
    logic [NB_REG-1:0][ADDR_WIDTH-1:0]   base_q;
    logic [NB_REG-1:0][ADDR_WIDTH-1:0]   fifo_addr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]               fifo_last;
    logic [PTR_W-1:0]                    wr_ptr, rd_ptr, newest_ptr;
    logic [CNT_W-1:0]                    count;
    logic                                empty, full, push, pop, drop, mark_last;
    logic [NB_REG-1:0][ADDR_WIDTH-1:0]   push_addr;
    logic                                soft_rst;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign soft_rst   = !rst_ni || clear_i;
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = !empty && cmd_ready_i;
    // A full buffer still takes a new entry when the head leaves in the same cycle.
    assign push       = (state == RUN) && uloop_valid_i && (!full || pop);
    assign drop       = (state == RUN) && uloop_valid_i && full && !pop;
    // uloop finished without a fresh offset set: the newest queued command closes the job.
    assign mark_last  = (state == RUN) && uloop_done_i && !uloop_valid_i && !empty;
    assign newest_ptr = (wr_ptr == '0) ? PTR_W'(FIFO_DEPTH - 1) : wr_ptr - PTR_W'(1);

    // Per-lane address: latched base plus zero-extended (or truncated) offset, wrapping on overflow.
    always_comb begin
        push_addr = '0;
        for (int k = 0; k < NB_REG; k++) begin
            push_addr[k] = base_q[k] + ADDR_WIDTH'(uloop_offs_i[k]);
        end
    end

    // State register; clear behaves exactly like reset.
    always_ff @(posedge clk_i) begin
        if (soft_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: one clear cycle, run until uloop ends, drain until the buffer empties.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)      state_nxt = CLEAR;
            CLEAR:                     state_nxt = RUN;
            RUN:     if (uloop_done_i) state_nxt = DRAIN;
            DRAIN:   if (empty)        state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and buffer occupancy only.
    always_comb begin
        busy_o         = (state != IDLE);
        uloop_clear_o  = (state == CLEAR);
        uloop_enable_o = (state == RUN) && (count <= CNT_W'(FIFO_DEPTH - 2));
        done_o         = (state == DRAIN) && empty;
        cmd_valid_o    = !empty;
        cmd_addr_o     = empty ? '0 : fifo_addr[rd_ptr];
        cmd_last_o     = empty ? 1'b0 : fifo_last[rd_ptr];
    end

    // Base registers captured only when a job is accepted.
    always_ff @(posedge clk_i) begin
        if (soft_rst)                       base_q <= '0;
        else if (state == IDLE && start_i)  base_q <= base_addr_i;
    end

    // Buffer pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
            if (drop) overflow_o <= 1'b1;
        end
    end

    // Buffer storage; contents are masked at the outputs while empty, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_last[wr_ptr] <= uloop_done_i;
        end else if (mark_last) begin
            fifo_last[newest_ptr] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_uloop_sched.sv
// Bench for hwpe_ctrl_uloop_sched: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_hwpe_ctrl_uloop_sched;
    localparam int NB = 4;
    localparam int AW = 32;
    localparam int RW = 32;
    localparam int D  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, clear, start, uvalid, udone, ready;
    logic [NB-1:0][AW-1:0] base, caddr;
    logic [NB-1:0][RW-1:0] offs;
    logic busy, done, ovf, uclr, uen, cvalid, clast;

    hwpe_ctrl_uloop_sched #(.NB_REG(NB), .REG_WIDTH(RW), .ADDR_WIDTH(AW), .FIFO_DEPTH(D)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
        .base_addr_i(base), .busy_o(busy), .done_o(done), .overflow_o(ovf),
        .uloop_clear_o(uclr), .uloop_enable_o(uen), .uloop_valid_i(uvalid),
        .uloop_done_i(udone), .uloop_offs_i(offs), .cmd_valid_o(cvalid),
        .cmd_ready_i(ready), .cmd_addr_o(caddr), .cmd_last_o(clast)
    );

    int n_vec = 0;
    int n_err = 0;
    bit model_chk = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model: a job phase, a command queue, a sticky flag ----------------
    typedef struct {
        logic [NB-1:0][AW-1:0] addr;
        bit                    last;
    } cmd_t;

    cmd_t                  mq[$];
    int                    m_phase = 0;   // 0 idle, 1 clearing, 2 running, 3 draining
    bit                    m_ovf = 0;
    logic [NB-1:0][AW-1:0] m_base = '0;

    task automatic model_update();
        int   nphase;
        bit   pop, was_full;
        cmd_t c;
        if (!rst_n || clear) begin
            m_phase = 0; mq.delete(); m_ovf = 0; m_base = '0;
            return;
        end
        nphase   = m_phase;
        pop      = (mq.size() > 0) && ready;
        was_full = (mq.size() == D);
        case (m_phase)
            0: if (start) begin nphase = 1; m_base = base; end
            1: nphase = 2;
            2: if (udone) nphase = 3;
            3: if (mq.size() == 0) nphase = 0;
            default: nphase = 0;
        endcase
        if (m_phase == 2 && udone && !uvalid && mq.size() > 0) begin
            c = mq[mq.size()-1];
            c.last = 1;
            mq[mq.size()-1] = c;
        end
        if (pop) void'(mq.pop_front());
        if (m_phase == 2 && uvalid) begin
            if (!was_full || pop) begin
                for (int k = 0; k < NB; k++) c.addr[k] = m_base[k] + offs[k];
                c.last = udone;
                mq.push_back(c);
            end else begin
                m_ovf = 1;
            end
        end
        m_phase = nphase;
    endtask

    task automatic compare_model();
        int sz;
        sz = mq.size();
        chk("m_busy", busy, m_phase != 0);
        chk("m_uclr", uclr, m_phase == 1);
        chk("m_uen", uen, (m_phase == 2) && (sz <= D - 2));
        chk("m_done", done, (m_phase == 3) && (sz == 0));
        chk("m_ovf", ovf, m_ovf);
        chk("m_cvalid", cvalid, sz > 0);
        chk("m_addr", caddr, (sz > 0) ? mq[0].addr : '0);
        chk("m_last", clast, (sz > 0) ? mq[0].last : 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        if (model_chk) compare_model();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst_n, clear, start, valid, done, ready;
        logic [31:0] b0, b1, o0, o1;
        bit          e_busy, e_uclr, e_en, e_cv, e_last, e_done, e_ovf;
        logic [31:0] e_a0, e_a1;
    } vec_t;

    vec_t tbl[13];

    initial begin
        rst_n = 0; clear = 0; start = 0; uvalid = 0; udone = 0; ready = 0;
        base = '0; offs = '0;

        //           rst clr st  vl dn rd  b0            b1            o0     o1      busy uclr en cv last done ovf a0            a1
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  32'h0,  0, 0, 0, 0, 0, 0, 0, 32'h0,    32'h0};
        tbl[1]  = '{1, 0, 1, 0, 0, 0, 32'h1000,     32'h2000,     32'h0,  32'h0,  1, 1, 0, 0, 0, 0, 0, 32'h0,    32'h0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 32'h1000,     32'h2000,     32'h0,  32'h0,  1, 0, 1, 0, 0, 0, 0, 32'h0,    32'h0};
        tbl[3]  = '{1, 0, 0, 1, 0, 1, 32'h1000,     32'h2000,     32'h4,  32'h8,  1, 0, 0, 1, 0, 0, 0, 32'h1004, 32'h2008};
        tbl[4]  = '{1, 0, 0, 1, 1, 1, 32'h1000,     32'h2000,     32'h10, 32'h20, 1, 0, 0, 1, 1, 0, 0, 32'h1010, 32'h2020};
        tbl[5]  = '{1, 0, 0, 0, 0, 1, 32'h1000,     32'h2000,     32'h0,  32'h0,  1, 0, 0, 0, 0, 1, 0, 32'h0,    32'h0};
        tbl[6]  = '{1, 0, 0, 0, 0, 1, 32'h1000,     32'h2000,     32'h0,  32'h0,  0, 0, 0, 0, 0, 0, 0, 32'h0,    32'h0};
        tbl[7]  = '{1, 0, 1, 0, 0, 0, 32'hFFFFFFF0, 32'h0,        32'h0,  32'h0,  1, 1, 0, 0, 0, 0, 0, 32'h0,    32'h0};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 32'hFFFFFFF0, 32'h0,        32'h0,  32'h0,  1, 0, 1, 0, 0, 0, 0, 32'h0,    32'h0};
        tbl[9]  = '{1, 0, 0, 1, 0, 0, 32'hFFFFFFF0, 32'h0,        32'h20, 32'h0,  1, 0, 0, 1, 0, 0, 0, 32'h10,   32'h0};
        tbl[10] = '{1, 0, 0, 0, 1, 0, 32'hFFFFFFF0, 32'h0,        32'h0,  32'h0,  1, 0, 0, 1, 1, 0, 0, 32'h10,   32'h0};
        tbl[11] = '{1, 0, 0, 0, 0, 1, 32'hFFFFFFF0, 32'h0,        32'h0,  32'h0,  1, 0, 0, 0, 0, 1, 0, 32'h0,    32'h0};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 32'hFFFFFFF0, 32'h0,        32'h0,  32'h0,  0, 0, 0, 0, 0, 0, 0, 32'h0,    32'h0};

        for (int i = 0; i < 13; i++) begin
            rst_n = tbl[i].rst_n; clear = tbl[i].clear; start = tbl[i].start;
            uvalid = tbl[i].valid; udone = tbl[i].done; ready = tbl[i].ready;
            base = '0; offs = '0;
            base[0] = tbl[i].b0; base[1] = tbl[i].b1;
            offs[0] = tbl[i].o0; offs[1] = tbl[i].o1;
            tick();
            chk($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("t%0d_uclr", i), uclr, tbl[i].e_uclr);
            chk($sformatf("t%0d_uen", i), uen, tbl[i].e_en);
            chk($sformatf("t%0d_cvalid", i), cvalid, tbl[i].e_cv);
            chk($sformatf("t%0d_last", i), clast, tbl[i].e_last);
            chk($sformatf("t%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("t%0d_ovf", i), ovf, tbl[i].e_ovf);
            chk($sformatf("t%0d_addr0", i), caddr[0], tbl[i].e_a0);
            chk($sformatf("t%0d_addr1", i), caddr[1], tbl[i].e_a1);
        end
        start = 0; uvalid = 0; udone = 0; ready = 0; offs = '0;

        // ---- backpressure: buffer fills, enable drops, head holds, third set is lost ----
        base = '0; base[0] = 32'h100; base[1] = 32'h200;
        start = 1; tick(); start = 0; tick();
        chk("bp_en_empty", uen, 1'b1);
        uvalid = 1; offs[0] = 32'h1; tick();
        chk("bp_en_cnt1", uen, 1'b0);
        chk("bp_head1", caddr[0], 32'h101);
        offs[0] = 32'h2; tick();
        chk("bp_ovf_full", ovf, 1'b0);
        offs[0] = 32'h3; tick();
        chk("bp_ovf_set", ovf, 1'b1);
        uvalid = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("bp_hold_addr", caddr[0], 32'h101);
            chk("bp_hold_valid", cvalid, 1'b1);
            chk("bp_hold_last", clast, 1'b0);
        end
        udone = 1; tick(); udone = 0;
        ready = 1; tick();
        chk("bp_second", caddr[0], 32'h102);
        chk("bp_second_last", clast, 1'b1);
        tick();
        chk("bp_lost_empty", cvalid, 1'b0);
        chk("bp_done", done, 1'b1);
        chk("bp_ovf_sticky", ovf, 1'b1);
        ready = 0; tick();
        clear = 1; tick(); clear = 0;
        chk("bp_ovf_cleared", ovf, 1'b0);

        // ---- clear while running with two queued entries ----
        base[0] = 32'h500; start = 1; tick(); start = 0; tick();
        uvalid = 1; offs[0] = 32'h0; tick(); tick(); uvalid = 0;
        chk("clr_queued", cvalid, 1'b1);
        clear = 1; tick(); clear = 0;
        chk("clr_busy", busy, 1'b0);
        chk("clr_cvalid", cvalid, 1'b0);
        chk("clr_done", done, 1'b0);
        chk("clr_uclr", uclr, 1'b0);
        tick();
        chk("clr_done_after", done, 1'b0);
        chk("clr_idle", busy, 1'b0);

        // ---- start during a running job is ignored ----
        base[0] = 32'h700; start = 1; tick(); start = 0; tick();
        base[0] = 32'h900; start = 1; tick(); start = 0;
        chk("rs_busy", busy, 1'b1);
        chk("rs_uclr", uclr, 1'b0);
        uvalid = 1; offs[0] = 32'h5; tick(); uvalid = 0;
        chk("rs_base_kept", caddr[0], 32'h705);
        udone = 1; tick(); udone = 0;
        ready = 1; tick(); tick(); tick(); ready = 0;
        chk("rs_back_idle", busy, 1'b0);

        // ---- randomized traffic against the model ----
        rst_n = 0; tick(); rst_n = 1;
        model_chk = 1;
        for (int i = 0; i < 3000; i++) begin
            rst_n  = ($urandom_range(0, 255) != 0);
            clear  = ($urandom_range(0, 127) == 0);
            start  = ($urandom_range(0, 7) == 0);
            uvalid = ($urandom_range(0, 1) == 1);
            udone  = ($urandom_range(0, 19) == 0);
            ready  = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < NB; k++) begin
                base[k] = ($urandom_range(0, 3) == 0) ? (32'hFFFFFF00 | 32'($urandom_range(0, 255))) : $urandom;
                offs[k] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
            end
            tick();
        end
        model_chk = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
